c1541_gcr_dec: RTL and testbench
================================

# c1541_gcr_dec

Bit-serial GCR track decoder for the 1541 drive model: the read-back counterpart of the D64 track generator. It consumes a raw per-bit-cell stream (from a G64 track buffer or a write-captured track), hunts for sync marks, frames and GCR-decodes 5-bit groups into bytes, and validates header and data blocks. Decoded sector payloads are written into a 256-byte sector buffer, with a per-block status pulse. It sits between the track bit source and the D64 sector RAM, which the D64 generator reads.

## Interface
Parameters: none (geometry fixed to 1541 format: 35 tracks, sectors 0..20).
- clk32  in  1  system clock, 32 MHz
- reset  in  1  synchronous, active-high
- bit_en  in  1  one-cycle strobe per bit cell; `bit_in` is sampled only when high
- bit_in  in  1  raw bit cell value
- track  in  6  expected track number (1..35)
- sync  out  1  high while in a sync mark (≥10 consecutive ones)
- sector  out  5  sector number from the last accepted header
- ram_addr  out  8  payload byte index 0..255
- ram_di  out  8  decoded payload byte
- ram_we  out  1  one-cycle write strobe
- stat_valid  out  1  one-cycle pulse at the end of each header or data block
- stat_hdr  out  1  qualifies `stat_valid`: 1 = header block, 0 = data block
- err  out  3  block status: 0 ok, 1 header cks, 2 data cks, 3 bad GCR code, 4 truncated by sync, 5 track mismatch / sector > 20, 6 data block without header

## Operation
- Sync detector: `ones_cnt` is a 4-bit counter saturating at 10. It increments on `bit_en & bit_in` and clears on `bit_en & ~bit_in`. `sync` = (ones_cnt == 10).
- Framing: the first 0 bit after sync is bit 4 of the first 5-bit group. Each 10 bits (two groups, high nibble first) form one byte. GCR decode table: 01010→0, 01011→1, 10010→2, 10011→3, 01110→4, 01111→5, 10110→6, 10111→7, 01001→8, 11001→9, 11010→A, 11011→B, 01101→C, 11101→D, 11110→E, 10101→F. Any other code decodes as 0 and sets the sticky `gcr_bad` flag for the current block.
- States:
  - HUNT: wait for sync to end. On the first 0 bit, go to ID.
  - ID: byte 0x08 → HDR. Byte 0x07 → DATA if `hdr_ok`, else `stat_valid` with err=6 and go to HUNT. Any other byte → HUNT, no pulse.
  - HDR: collect cks, sector, track, id2, id1 (5 bytes). Then evaluate in this priority order: gcr_bad → 3; cks ≠ sector^track^id2^id1 → 1; track ≠ `track` or sector > 20 → 5; else 0. Pulse `stat_valid` with stat_hdr=1. If err=0: latch `sector` and set `hdr_ok`. Go to HUNT. The trailing 0x0F gap bytes are ignored.
  - DATA: bytes 1..256 are written to ram_addr 0..255 with a running XOR checksum; byte 257 is compared with it. Evaluate: gcr_bad → 3; mismatch → 2; else 0. Pulse with stat_hdr=0. Clear `hdr_ok`. Go to HUNT. Off-bytes are ignored.
- Sync in HDR or DATA (ones_cnt reaches 10 mid-block): abort, pulse err=4 with stat_hdr set per block type, clear `hdr_ok`, and resume framing after the sync ends. Bytes already written to RAM are not rolled back.
- A change on `track` clears `hdr_ok` and sets `sector` to 0, from any state, and forces HUNT.
- Checksums and counters use 8-bit wrap arithmetic. The payload byte counter is 9 bits wide.

## Timing
- Reset values: sync=0, sector=0, ram_addr=0, ram_di=0, ram_we=0, stat_valid=0, stat_hdr=0, err=0, `hdr_ok`=0, state=HUNT, ones_cnt=0.
- Byte completion is the `bit_en` cycle of the 10th bit, cycle N.
  - At N+1: ram_we/ram_addr/ram_di are valid for one cycle.
  - At N+1: stat_valid/stat_hdr/err are valid for the block's final byte. `err` holds its value until the next pulse.
- `sync` rises in the cycle after the 10th consecutive one is sampled. It falls in the cycle after the terminating 0 is sampled.
- Any number of idle clocks between `bit_en` strobes is legal. The minimum spacing between strobes is 2 clocks.
- Reset mid-block: no pulse, no write. All outputs return to their reset values on the next edge.

## Test plan
- Reset, then 40 ones, 0-started GCR header (08, cks, sec=5, trk=18, id 41/42, 0F, 0F) with track=18 → one stat_valid, stat_hdr=1, err=0, sector=5.
- Valid header, sync, data block 07 + bytes i (0..255) + correct cks → 256 ram_we pulses with ram_addr=ram_di=i, then stat_valid, stat_hdr=0, err=0.
- Same data block with checksum byte +1 → all 256 writes occur, then err=2. A following data block without a new header → err=6 and no writes.
- Header with track field 17 while track=18 → err=5. A subsequent data block is rejected with err=6.
- GCR group 00000 injected at payload byte 10 → err=3 at block end. A 10-ones run injected at payload byte 100 → err=4 at the abort, with `sync` high.
- `track` changed during DATA → no further writes, no pulse, sector=0, and the next data block gives err=6.

Source files
------------

// File: rtl/c1541_gcr_dec_if.sv
// rtl/c1541_gcr_dec_if.sv - bit source, sector RAM write and block status signals of the GCR decoder
interface c1541_gcr_dec_if;
    logic       bit_en;
    logic       bit_in;
    logic [5:0] track;
    logic       sync;
    logic [4:0] sector;
    logic [7:0] ram_addr;
    logic [7:0] ram_di;
    logic       ram_we;
    logic       stat_valid;
    logic       stat_hdr;
    logic [2:0] err;

    modport master (
        output bit_en, bit_in, track,
        input  sync, sector, ram_addr, ram_di, ram_we, stat_valid, stat_hdr, err
    );

    modport slave (
        input  bit_en, bit_in, track,
        output sync, sector, ram_addr, ram_di, ram_we, stat_valid, stat_hdr, err
    );
endinterface

// File: rtl/c1541_gcr_dec.sv
// rtl/c1541_gcr_dec.sv - bit-serial 1541 GCR decoder: sync hunt, framing, header/data validation
module c1541_gcr_dec (
    input  logic           clk32,
    input  logic           reset,
    c1541_gcr_dec_if.slave bus
);
    typedef enum logic [1:0] {HUNT, ID, HDR, DATA} state_t;

    state_t     state;
    logic [3:0] ones_cnt;
    logic [8:0] shreg;
    logic [3:0] bit_cnt;
    logic [8:0] byte_cnt;
    logic [7:0] acc;
    logic [7:0] sec_rx;
    logic [7:0] trk_rx;
    logic       gcr_bad;
    logic       hdr_ok;
    logic [5:0] track_q;

    // Returns {bad, nibble}; illegal codes decode as 0 with bad set.
    function automatic logic [4:0] gcr_nib(input logic [4:0] code);
        logic [4:0] r;
        case (code)
            5'b01010: r = 5'h00;
            5'b01011: r = 5'h01;
            5'b10010: r = 5'h02;
            5'b10011: r = 5'h03;
            5'b01110: r = 5'h04;
            5'b01111: r = 5'h05;
            5'b10110: r = 5'h06;
            5'b10111: r = 5'h07;
            5'b01001: r = 5'h08;
            5'b11001: r = 5'h09;
            5'b11010: r = 5'h0A;
            5'b11011: r = 5'h0B;
            5'b01101: r = 5'h0C;
            5'b11101: r = 5'h0D;
            5'b11110: r = 5'h0E;
            5'b10101: r = 5'h0F;
            default:  r = 5'h10;
        endcase
        return r;
    endfunction

    logic [9:0] word;
    logic [4:0] dec_hi;
    logic [4:0] dec_lo;
    logic [7:0] byte_val;
    logic       gcr_bad_n;
    logic       sync_hit;
    logic [2:0] hdr_err;
    logic [2:0] dat_err;

    // acc holds the XOR of all bytes before the last one, so a match means the block checksum holds.
    always_comb begin
        word      = {shreg, bus.bit_in};
        dec_hi    = gcr_nib(word[9:5]);
        dec_lo    = gcr_nib(word[4:0]);
        byte_val  = {dec_hi[3:0], dec_lo[3:0]};
        gcr_bad_n = gcr_bad | dec_hi[4] | dec_lo[4];
        sync_hit  = bus.bit_en & bus.bit_in & (ones_cnt == 4'd9);
        hdr_err   = 3'd0;
        if (gcr_bad_n)
            hdr_err = 3'd3;
        else if (acc != byte_val)
            hdr_err = 3'd1;
        else if (trk_rx != {2'b00, bus.track} || sec_rx > 8'd20)
            hdr_err = 3'd5;
        dat_err = gcr_bad_n ? 3'd3 : (acc != byte_val) ? 3'd2 : 3'd0;
    end

    assign bus.sync = (ones_cnt == 4'd10);

    always_ff @(posedge clk32) begin
        if (reset) begin
            state          <= HUNT;
            ones_cnt       <= 4'd0;
            shreg          <= 9'd0;
            bit_cnt        <= 4'd0;
            byte_cnt       <= 9'd0;
            acc            <= 8'd0;
            sec_rx         <= 8'd0;
            trk_rx         <= 8'd0;
            gcr_bad        <= 1'b0;
            hdr_ok         <= 1'b0;
            track_q        <= bus.track;
            bus.sector     <= 5'd0;
            bus.ram_addr   <= 8'd0;
            bus.ram_di     <= 8'd0;
            bus.ram_we     <= 1'b0;
            bus.stat_valid <= 1'b0;
            bus.stat_hdr   <= 1'b0;
            bus.err        <= 3'd0;
        end else begin
            bus.ram_we     <= 1'b0;
            bus.stat_valid <= 1'b0;
            track_q        <= bus.track;

            if (bus.bit_en) begin
                if (!bus.bit_in)
                    ones_cnt <= 4'd0;
                else if (ones_cnt != 4'd10)
                    ones_cnt <= ones_cnt + 4'd1;
            end

            if (bus.track != track_q) begin
                hdr_ok     <= 1'b0;
                bus.sector <= 5'd0;
                state      <= HUNT;
            end else if (bus.bit_en) begin
                case (state)
                    HUNT: begin
                        // The zero that ends a sync mark is the first bit of the ID byte.
                        if (!bus.bit_in && ones_cnt == 4'd10) begin
                            state    <= ID;
                            shreg    <= 9'd0;
                            bit_cnt  <= 4'd1;
                            byte_cnt <= 9'd0;
                            acc      <= 8'd0;
                            gcr_bad  <= 1'b0;
                        end
                    end
                    default: begin
                        if (sync_hit) begin
                            if (state != ID) begin
                                bus.stat_valid <= 1'b1;
                                bus.stat_hdr   <= (state == HDR);
                                bus.err        <= 3'd4;
                                hdr_ok         <= 1'b0;
                            end
                            state <= HUNT;
                        end else if (bit_cnt != 4'd9) begin
                            shreg   <= {shreg[7:0], bus.bit_in};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            bit_cnt  <= 4'd0;
                            gcr_bad  <= gcr_bad_n;
                            byte_cnt <= byte_cnt + 9'd1;
                            case (state)
                                ID: begin
                                    byte_cnt <= 9'd0;
                                    acc      <= 8'd0;
                                    if (byte_val == 8'h08) begin
                                        state <= HDR;
                                    end else if (byte_val == 8'h07 && hdr_ok) begin
                                        state <= DATA;
                                    end else begin
                                        state <= HUNT;
                                        if (byte_val == 8'h07) begin
                                            bus.stat_valid <= 1'b1;
                                            bus.stat_hdr   <= 1'b0;
                                            bus.err        <= 3'd6;
                                        end
                                    end
                                end
                                HDR: begin
                                    acc <= acc ^ byte_val;
                                    if (byte_cnt == 9'd1) sec_rx <= byte_val;
                                    if (byte_cnt == 9'd2) trk_rx <= byte_val;
                                    if (byte_cnt == 9'd4) begin
                                        state          <= HUNT;
                                        bus.stat_valid <= 1'b1;
                                        bus.stat_hdr   <= 1'b1;
                                        bus.err        <= hdr_err;
                                        hdr_ok         <= (hdr_err == 3'd0);
                                        if (hdr_err == 3'd0)
                                            bus.sector <= sec_rx[4:0];
                                    end
                                end
                                DATA: begin
                                    if (byte_cnt[8]) begin
                                        state          <= HUNT;
                                        bus.stat_valid <= 1'b1;
                                        bus.stat_hdr   <= 1'b0;
                                        bus.err        <= dat_err;
                                        hdr_ok         <= 1'b0;
                                    end else begin
                                        bus.ram_we   <= 1'b1;
                                        bus.ram_addr <= byte_cnt[7:0];
                                        bus.ram_di   <= byte_val;
                                        acc          <= acc ^ byte_val;
                                    end
                                end
                                default: state <= HUNT;
                            endcase
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_c1541_gcr_dec.sv
// tb/tb_c1541_gcr_dec.sv - randomized self-checking bench for the GCR track decoder
module tb_c1541_gcr_dec;
    logic clk32 = 1'b0;
    logic reset;
    always #16 clk32 = ~clk32;

    c1541_gcr_dec_if bus ();
    c1541_gcr_dec dut (.clk32(clk32), .reset(reset), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;

    logic [4:0] enc [16] = '{5'b01010, 5'b01011, 5'b10010, 5'b10011,
                             5'b01110, 5'b01111, 5'b10110, 5'b10111,
                             5'b01001, 5'b11001, 5'b11010, 5'b11011,
                             5'b01101, 5'b11101, 5'b11110, 5'b10101};

    logic [7:0] payload [256];
    logic [7:0] exp_wr  [256];
    int         n_exp_wr;
    logic       hdr_ok_m;
    logic [4:0] sector_m;

    logic [7:0] wr_addr_q [$];
    logic [7:0] wr_di_q   [$];
    logic [4:0] st_q      [$];

    always @(negedge clk32) begin
        if (bus.ram_we === 1'b1) begin
            wr_addr_q.push_back(bus.ram_addr);
            wr_di_q.push_back(bus.ram_di);
        end
        if (bus.stat_valid === 1'b1)
            st_q.push_back({bus.sync, bus.stat_hdr, bus.err});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk32);
        bus.bit_en = 1'b1;
        bus.bit_in = b;
        @(negedge clk32);
        bus.bit_en = 1'b0;
        bus.bit_in = 1'($urandom);
        repeat ($urandom_range(0, 1)) @(negedge clk32);
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_group(input logic [4:0] g);
        for (int i = 4; i >= 0; i--) send_bit(g[i]);
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_group(enc[v[7:4]]);
        send_group(enc[v[3:0]]);
    endtask

    // Compares captured writes/pulses of one block against the model, then clears the capture.
    task automatic check_block(input string tag, input int n_pulse, input logic [2:0] e, input logic hdr);
        chk({tag, ".n_writes"}, wr_di_q.size(), n_exp_wr);
        for (int i = 0; i < wr_di_q.size() && i < n_exp_wr; i++) begin
            chk({tag, ".ram_addr"}, wr_addr_q[i], i);
            chk({tag, ".ram_di"}, wr_di_q[i], exp_wr[i]);
        end
        chk({tag, ".n_pulses"}, st_q.size(), n_pulse);
        if (n_pulse > 0 && st_q.size() > 0) begin
            chk({tag, ".stat_hdr"}, st_q[0][3], hdr);
            chk({tag, ".err"}, st_q[0][2:0], e);
            chk({tag, ".sync_at_pulse"}, st_q[0][4], (e == 3'd4));
            chk({tag, ".err_hold"}, bus.err, e);
        end
        chk({tag, ".sector"}, bus.sector, sector_m);
        wr_addr_q.delete();
        wr_di_q.delete();
        st_q.delete();
    endtask

    task automatic header_block(input string tag, input logic [7:0] sec, input logic [7:0] trk,
                                input logic [7:0] id2, input logic [7:0] id1, input logic [7:0] cks_delta);
        logic [7:0] cks;
        logic [2:0] e;
        cks = sec ^ trk ^ id2 ^ id1 ^ cks_delta;
        send_ones(40);
        send_byte(8'h08);
        send_byte(cks);
        send_byte(sec);
        send_byte(trk);
        send_byte(id2);
        send_byte(id1);
        send_byte(8'h0F);
        send_byte(8'h0F);
        repeat (4) @(negedge clk32);
        if (cks != (sec ^ trk ^ id2 ^ id1))
            e = 3'd1;
        else if (trk != {2'b00, bus.track} || sec > 8'd20)
            e = 3'd5;
        else
            e = 3'd0;
        if (e == 3'd0) begin
            hdr_ok_m = 1'b1;
            sector_m = sec[4:0];
        end
        n_exp_wr = 0;
        check_block(tag, 1, e, 1'b1);
    endtask

    // mode 0 normal, 1 bad group at pos, 2 ten ones at pos, 3 track change at pos, 4 reset at pos
    task automatic data_block(input string tag, input int mode, input int pos, input logic [7:0] cks_delta);
        logic [7:0] sum;
        logic [7:0] cks_rx;
        int stop;
        logic [2:0] e;
        int n_pulse;
        sum = 8'd0;
        stop = (mode >= 2) ? pos : 256;
        n_exp_wr = 0;
        if (hdr_ok_m) begin
            for (int i = 0; i < stop; i++) begin
                exp_wr[i] = (mode == 1 && i == pos) ? {4'h0, payload[i][3:0]} : payload[i];
                sum ^= exp_wr[i];
            end
            n_exp_wr = stop;
        end
        for (int i = 0; i < 256; i++) cks_rx ^= 8'd0;
        cks_rx = 8'd0;
        for (int i = 0; i < 256; i++) cks_rx ^= payload[i];
        cks_rx ^= cks_delta;

        send_ones(40);
        send_byte(8'h07);
        for (int i = 0; i < 256; i++) begin
            if (i == pos && mode == 2) begin
                send_ones(10);
                send_byte(8'h0F);
                break;
            end
            if (i == pos && mode == 4) begin
                @(negedge clk32);
                reset = 1'b1;
                @(negedge clk32);
                reset = 1'b0;
                chk({tag, ".rst_ram_we"}, bus.ram_we, 1'b0);
                chk({tag, ".rst_ram_addr"}, bus.ram_addr, 8'd0);
                chk({tag, ".rst_ram_di"}, bus.ram_di, 8'd0);
                chk({tag, ".rst_stat_valid"}, bus.stat_valid, 1'b0);
                chk({tag, ".rst_err"}, bus.err, 3'd0);
                chk({tag, ".rst_sync"}, bus.sync, 1'b0);
                break;
            end
            if (i == pos && mode == 3)
                bus.track = bus.track - 6'd1;
            if (i == pos && mode == 1) begin
                send_group(5'b00000);
                send_group(enc[payload[i][3:0]]);
            end else begin
                send_byte(payload[i]);
            end
        end
        if (mode == 0 || mode == 1 || mode == 3) begin
            send_byte(cks_rx);
            send_byte(8'h0F);
        end
        repeat (4) @(negedge clk32);

        n_pulse = 1;
        if (!hdr_ok_m)
            e = 3'd6;
        else if (mode == 1)
            e = 3'd3;
        else if (mode == 2)
            e = 3'd4;
        else if (mode == 0)
            e = (cks_rx != sum) ? 3'd2 : 3'd0;
        else begin
            e = 3'd0;
            n_pulse = 0;
            sector_m = 5'd0;
        end
        hdr_ok_m = 1'b0;
        check_block(tag, n_pulse, e, 1'b0);
    endtask

    initial begin
        bus.bit_en = 1'b0;
        bus.bit_in = 1'b0;
        bus.track  = 6'd18;
        reset      = 1'b1;
        hdr_ok_m   = 1'b0;
        sector_m   = 5'd0;
        repeat (4) @(negedge clk32);
        reset = 1'b0;
        @(negedge clk32);
        chk("reset.sync", bus.sync, 1'b0);
        chk("reset.sector", bus.sector, 5'd0);
        chk("reset.ram_addr", bus.ram_addr, 8'd0);
        chk("reset.ram_di", bus.ram_di, 8'd0);
        chk("reset.ram_we", bus.ram_we, 1'b0);
        chk("reset.stat_valid", bus.stat_valid, 1'b0);
        chk("reset.stat_hdr", bus.stat_hdr, 1'b0);
        chk("reset.err", bus.err, 3'd0);

        header_block("hdr5", 8'd5, 8'd18, 8'h41, 8'h42, 8'h00);
        for (int i = 0; i < 256; i++) payload[i] = 8'(i);
        data_block("data_ramp", 0, 300, 8'h00);

        header_block("hdr_rand", 8'($urandom_range(0, 20)), 8'd18, 8'($urandom), 8'($urandom), 8'h00);
        for (int i = 0; i < 256; i++) payload[i] = 8'($urandom);
        data_block("data_cks_plus1", 0, 300, 8'h01);
        data_block("data_no_hdr", 0, 300, 8'h00);

        header_block("hdr_trk17", 8'd3, 8'd17, 8'($urandom), 8'($urandom), 8'h00);
        data_block("data_after_bad_hdr", 0, 300, 8'h00);

        header_block("hdr_bad_cks", 8'd7, 8'd18, 8'($urandom), 8'($urandom), 8'h80);
        header_block("hdr_sec21", 8'd21, 8'd18, 8'($urandom), 8'($urandom), 8'h00);
        header_block("hdr_sec20", 8'd20, 8'd18, 8'($urandom), 8'($urandom), 8'h00);
        for (int i = 0; i < 256; i++) payload[i] = 8'($urandom);
        data_block("data_bad_gcr", 1, 10, 8'h00);

        header_block("hdr_pre_sync", 8'($urandom_range(0, 20)), 8'd18, 8'($urandom), 8'($urandom), 8'h00);
        data_block("data_sync_abort", 2, 100, 8'h00);

        header_block("hdr_pre_trkchg", 8'($urandom_range(0, 20)), 8'd18, 8'($urandom), 8'($urandom), 8'h00);
        data_block("data_trk_change", 3, 50, 8'h00);
        data_block("data_after_trkchg", 0, 300, 8'h00);

        header_block("hdr_trk17_ok", 8'($urandom_range(0, 20)), 8'd17, 8'($urandom), 8'($urandom), 8'h00);
        data_block("data_reset_mid", 4, 20, 8'h00);
        data_block("data_after_reset", 0, 300, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
